// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared types and default weights for the Needleman-Wunsch blocks
// Contents: op_t (traceback operation encoding), state_t (traceback FSM states),
//           NW_MATCH / NW_INDEL / NW_MISMATCH default weights shared with the grid.
package nw_pkg;

    typedef enum logic [1:0] {
        OP_MATCH    = 2'b00,
        OP_MISMATCH = 2'b01,
        OP_UP       = 2'b10,
        OP_LEFT     = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_CUR,
        S_FETCH_DIAG,
        S_FETCH_UP,
        S_FETCH_LEFT,
        S_DECIDE,
        S_EMIT,
        S_FINISH
    } state_t;

    localparam int NW_MATCH    = 1;
    localparam int NW_INDEL    = -1;
    localparam int NW_MISMATCH = -1;

endpackage

// File: rtl/nw_tb_decide.sv
// rtl/nw_tb_decide.sv - combinational traceback direction choice for one interior cell
// Ports: cur/diag/up scores, c1/c2 the characters pairing at this cell,
//        w_match/w_mismatch/w_indel sign-extended weights, op chosen operation.
// Priority: diagonal, then UP, otherwise LEFT.
module nw_tb_decide
    import nw_pkg::*;
#(
    parameter int SWIDTH = 16,
    parameter int CWIDTH = 2
) (
    input  logic [SWIDTH-1:0] cur,
    input  logic [SWIDTH-1:0] diag,
    input  logic [SWIDTH-1:0] up,
    input  logic [CWIDTH-1:0] c1,
    input  logic [CWIDTH-1:0] c2,
    input  logic [SWIDTH-1:0] w_match,
    input  logic [SWIDTH-1:0] w_mismatch,
    input  logic [SWIDTH-1:0] w_indel,
    output logic [1:0]        op
);

    logic              same;
    logic [SWIDTH-1:0] diag_sum;
    logic [SWIDTH-1:0] up_sum;

    assign same     = (c1 == c2);
    assign diag_sum = diag + (same ? w_match : w_mismatch);
    assign up_sum   = up + w_indel;

    always_comb begin
        op = OP_LEFT;
        if (cur == diag_sum) begin
            op = same ? OP_MATCH : OP_MISMATCH;
        end else if (cur == up_sum) begin
            op = OP_UP;
        end
    end

endmodule

// File: rtl/nw_traceback.sv
// rtl/nw_traceback.sv - Needleman-Wunsch traceback: walks H from (len1,len2) to (0,0)
// Ports: clk, rst (async active-high); start, len1, len2, s1, s2 job inputs;
//        rd_en, rd_row, rd_col, rd_data score memory read (1-cycle latency);
//        op_valid, op_ready, op operation stream (end of alignment first);
//        busy, done, final_score status; err sticky inconsistency flag.
// Option: NW_TB_CHECK_EN adds the FETCH_LEFT read and the LEFT consistency check;
//         without it err is tied to 0.
module nw_traceback
    import nw_pkg::*;
#(
    parameter int LENGTH   = 10,
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int AWIDTH   = 8,
    parameter int MATCH    = NW_MATCH,
    parameter int INDEL    = NW_INDEL,
    parameter int MISMATCH = NW_MISMATCH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AWIDTH-1:0]        len1,
    input  logic [AWIDTH-1:0]        len2,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    output logic                     rd_en,
    output logic [AWIDTH-1:0]        rd_row,
    output logic [AWIDTH-1:0]        rd_col,
    input  logic [SWIDTH-1:0]        rd_data,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [1:0]               op,
    output logic                     busy,
    output logic                     done,
    output logic [SWIDTH-1:0]        final_score,
    output logic                     err
);

    localparam logic [SWIDTH-1:0] W_MATCH    = SWIDTH'(MATCH);
    localparam logic [SWIDTH-1:0] W_MISMATCH = SWIDTH'(MISMATCH);
    localparam logic [SWIDTH-1:0] W_INDEL    = SWIDTH'(INDEL);

    state_t            state, state_n;
    logic [AWIDTH-1:0] i_q, j_q, i_n, j_n, im1, jm1;
    logic [SWIDTH-1:0] cur_q, diag_q, up_q, up_now;
    logic [1:0]        op_q, op_n, dec_op;
    logic [CWIDTH-1:0] c1, c2;
    logic              cap_cur;   // rd_data this cycle is the FETCH_CUR result
    logic              first_q;   // next FETCH_CUR result is H[len1][len2]

    assign im1 = i_q - AWIDTH'(1);
    assign jm1 = j_q - AWIDTH'(1);

    // Characters pairing at (i, j): s1[i-1] and s2[j-1]
    always_comb begin
        c1 = '0;
        c2 = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (im1 == AWIDTH'(k)) c1 = s1[k*CWIDTH +: CWIDTH];
            if (jm1 == AWIDTH'(k)) c2 = s2[k*CWIDTH +: CWIDTH];
        end
    end

`ifdef NW_TB_CHECK_EN
    logic err_q, err_set;
    // UP score was captured in FETCH_LEFT; rd_data in DECIDE is the LEFT score
    assign up_now = up_q;
    assign err    = err_q;
`else
    // Without FETCH_LEFT the UP score arrives on rd_data during DECIDE
    assign up_now = rd_data;
    assign err    = 1'b0;
`endif

    nw_tb_decide #(
        .SWIDTH (SWIDTH),
        .CWIDTH (CWIDTH)
    ) u_decide (
        .cur        (cur_q),
        .diag       (diag_q),
        .up         (up_now),
        .c1         (c1),
        .c2         (c2),
        .w_match    (W_MATCH),
        .w_mismatch (W_MISMATCH),
        .w_indel    (W_INDEL),
        .op         (dec_op)
    );

    always_comb begin
        state_n = state;
        i_n     = i_q;
        j_n     = j_q;
        op_n    = op_q;
`ifdef NW_TB_CHECK_EN
        err_set = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH_CUR;
                    i_n     = len1;
                    j_n     = len2;
                end
            end
            S_FETCH_CUR: begin
                if (i_q == '0 && j_q == '0) begin
                    state_n = S_FINISH;
                end else if (i_q == '0) begin
                    state_n = S_EMIT;
                    op_n    = OP_LEFT;
                end else if (j_q == '0) begin
                    state_n = S_EMIT;
                    op_n    = OP_UP;
                end else begin
                    state_n = S_FETCH_DIAG;
                end
            end
            S_FETCH_DIAG: state_n = S_FETCH_UP;
`ifdef NW_TB_CHECK_EN
            S_FETCH_UP:   state_n = S_FETCH_LEFT;
            S_FETCH_LEFT: state_n = S_DECIDE;
`else
            S_FETCH_UP:   state_n = S_DECIDE;
`endif
            S_DECIDE: begin
                op_n    = dec_op;
                state_n = S_EMIT;
`ifdef NW_TB_CHECK_EN
                if (dec_op == OP_LEFT && cur_q != rd_data + W_INDEL) begin
                    err_set = 1'b1;
                    state_n = S_FINISH;
                end
`endif
            end
            S_EMIT: begin
                if (op_ready) begin
                    if (op_q != OP_LEFT) i_n = im1;
                    if (op_q != OP_UP)   j_n = jm1;
                    if (i_n == '0 && j_n == '0) begin
                        state_n = S_FINISH;
                    end else if (i_n == '0) begin
                        state_n = S_EMIT;
                        op_n    = OP_LEFT;
                    end else if (j_n == '0) begin
                        state_n = S_EMIT;
                        op_n    = OP_UP;
                    end else if (op_q == OP_LEFT) begin
                        state_n = S_FETCH_CUR;
                    end else begin
                        state_n = S_FETCH_DIAG;
                    end
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            op_q        <= '0;
            cur_q       <= '0;
            diag_q      <= '0;
            up_q        <= '0;
            final_score <= '0;
            cap_cur     <= 1'b0;
            first_q     <= 1'b0;
`ifdef NW_TB_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            i_q     <= i_n;
            j_q     <= j_n;
            op_q    <= op_n;
            cap_cur <= (state == S_FETCH_CUR);
            if (state == S_IDLE && start) first_q <= 1'b1;
`ifdef NW_TB_CHECK_EN
            if (state == S_IDLE && start) err_q <= 1'b0;
            if (err_set)                  err_q <= 1'b1;
            if (state == S_FETCH_LEFT)    up_q  <= rd_data;
`else
            if (state == S_DECIDE)        up_q  <= rd_data;
`endif
            if (state == S_FETCH_UP) diag_q <= rd_data;
            // Moving diagonally or up reuses the neighbour already read as the new cur
            if (state == S_EMIT && op_ready) begin
                if (op_q == OP_UP)        cur_q <= up_q;
                else if (op_q != OP_LEFT) cur_q <= diag_q;
            end
            if (cap_cur) begin
                cur_q <= rd_data;
                if (first_q) begin
                    final_score <= rd_data;
                    first_q     <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_en  = 1'b0;
        rd_row = '0;
        rd_col = '0;
        case (state)
            S_FETCH_CUR:  begin rd_en = 1'b1; rd_row = i_q; rd_col = j_q; end
            S_FETCH_DIAG: begin rd_en = 1'b1; rd_row = im1; rd_col = jm1; end
            S_FETCH_UP:   begin rd_en = 1'b1; rd_row = im1; rd_col = j_q; end
            S_FETCH_LEFT: begin rd_en = 1'b1; rd_row = i_q; rd_col = jm1; end
            default:      rd_en = 1'b0;
        endcase
    end

    assign op_valid = (state == S_EMIT);
    assign op       = op_q;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FINISH);

endmodule

// File: tb/tb_nw_traceback.sv
// tb/tb_nw_traceback.sv - self-checking bench for nw_traceback with a preloaded score memory
module tb_nw_traceback;
    import nw_pkg::*;

    localparam int LENGTH = 10;
    localparam int CWIDTH = 2;
    localparam int SWIDTH = 16;
    localparam int AWIDTH = 8;
`ifdef NW_TB_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [AWIDTH-1:0]        len1, len2;
    logic [LENGTH*CWIDTH-1:0] s1, s2;
    logic                     rd_en;
    logic [AWIDTH-1:0]        rd_row, rd_col;
    logic [SWIDTH-1:0]        rd_data = '0;
    logic                     op_valid;
    logic                     op_ready;
    logic [1:0]               op;
    logic                     busy, done, err;
    logic [SWIDTH-1:0]        final_score;

    logic [SWIDTH-1:0] hmem [0:LENGTH][0:LENGTH];
    logic [1:0]        exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_reads, n_ops, n_extra, n_done, cycles, first_rd;

    nw_traceback dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len1        (len1),
        .len2        (len2),
        .s1          (s1),
        .s2          (s2),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .busy        (busy),
        .done        (done),
        .final_score (final_score),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= hmem[int'(rd_row)][int'(rd_col)];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference Needleman-Wunsch fill of the score memory
    task automatic fill(input int l1, input int l2);
        int h [0:LENGTH][0:LENGTH];
        int d, u, l;
        for (int r = 0; r <= LENGTH; r++)
            for (int c = 0; c <= LENGTH; c++) begin
                h[r][c]    = 0;
                hmem[r][c] = '0;
            end
        for (int r = 0; r <= l1; r++)
            for (int c = 0; c <= l2; c++) begin
                if (r == 0) h[r][c] = -c;
                else if (c == 0) h[r][c] = -r;
                else begin
                    d = h[r-1][c-1] +
                        ((s1[(r-1)*CWIDTH +: CWIDTH] == s2[(c-1)*CWIDTH +: CWIDTH]) ? 1 : -1);
                    u = h[r-1][c] - 1;
                    l = h[r][c-1] - 1;
                    h[r][c] = d;
                    if (u > h[r][c]) h[r][c] = u;
                    if (l > h[r][c]) h[r][c] = l;
                end
                hmem[r][c] = 16'(h[r][c]);
            end
    endtask

    task automatic walk(input int l1, input int l2, input int stall_op, input int stall_len);
        int stall_left;
        logic [1:0] e;
        n_reads = 0; n_ops = 0; n_extra = 0; n_done = 0; cycles = 0; first_rd = 0;
        stall_left = stall_len;
        len1 = AWIDTH'(l1);
        len2 = AWIDTH'(l2);
        @(negedge clk);
        start = 1'b1;
        while (n_done == 0 && cycles < 200) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (stall_left > 0 && op_valid && n_ops == stall_op) begin
                op_ready = 1'b0;
                chk("stall_op_valid", op_valid, 1);
                chk("stall_rd_en", rd_en, 0);
                if (exp_q.size() > 0) chk("stall_op_stable", op, exp_q[0]);
                stall_left--;
            end else begin
                op_ready = 1'b1;
            end
            if (rd_en) begin
                n_reads++;
                if (first_rd == 0) first_rd = cycles;
            end
            if (op_valid && op_ready) begin
                n_ops++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("op", op, e);
                end else begin
                    n_extra++;
                end
            end
            if (done) n_done++;
        end
        chk("done_seen", n_done, 1);
        chk("extra_ops", n_extra, 0);
        chk("ops_left", exp_q.size(), 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int act;
        rst = 1'b1; start = 1'b0; op_ready = 1'b1;
        len1 = '0; len2 = '0; s1 = '0; s2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op", op, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_row", rd_row, 0);
        chk("rst_rd_col", rd_col, 0);
        chk("rst_final", final_score, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // AC vs AC: MATCH, MATCH
        s1 = 20'h4; s2 = 20'h4; fill(2, 2);
        exp_q.push_back(OP_MATCH); exp_q.push_back(OP_MATCH);
        walk(2, 2, -1, 0);
        chk("c1_final", final_score, 16'd2);
        chk("c1_err", err, 0);
        chk("c1_reads", n_reads, 5 + 2*CHK);
        chk("c1_first_read", first_rd, 1);
        chk("c1_cycles", cycles, 10 + 2*CHK);

        // A vs AC: LEFT then MATCH, FETCH_CUR re-entered after LEFT
        s1 = 20'h0; s2 = 20'h4; fill(1, 2);
        exp_q.push_back(OP_LEFT); exp_q.push_back(OP_MATCH);
        walk(1, 2, -1, 0);
        chk("c2_final", final_score, 16'd0);
        chk("c2_reads", n_reads, 6 + 2*CHK);
        chk("c2_cycles", cycles, 11 + 2*CHK);
        chk("c2_err", err, 0);

        // Empty strings: one read, no ops
        s1 = 20'h0; s2 = 20'h0; fill(0, 0);
        walk(0, 0, -1, 0);
        chk("c0_final", final_score, 16'd0);
        chk("c0_ops", n_ops, 0);
        chk("c0_reads", n_reads, 1);
        chk("c0_cycles", cycles, 2);

        // Column boundary only: UP, UP without neighbour reads
        s1 = 20'h4; s2 = 20'h0; fill(2, 0);
        exp_q.push_back(OP_UP); exp_q.push_back(OP_UP);
        walk(2, 0, -1, 0);
        chk("c20_final", final_score, 16'hFFFE);
        chk("c20_reads", n_reads, 1);
        chk("c20_cycles", cycles, 4);

        // A vs C: single MISMATCH
        s1 = 20'h0; s2 = 20'h1; fill(1, 1);
        exp_q.push_back(OP_MISMATCH);
        walk(1, 1, -1, 0);
        chk("cmm_final", final_score, 16'hFFFF);
        chk("cmm_reads", n_reads, 3 + CHK);

        // AC vs AC with 5-cycle backpressure on the first op
        s1 = 20'h4; s2 = 20'h4; fill(2, 2);
        exp_q.push_back(OP_MATCH); exp_q.push_back(OP_MATCH);
        walk(2, 2, 0, 5);
        chk("stall_final", final_score, 16'd2);
        chk("stall_reads", n_reads, 5 + 2*CHK);
        chk("stall_cycles", cycles, 15 + 2*CHK);

        // Reset while parked in EMIT
        op_ready = 1'b0;
        len1 = 8'd2; len2 = 8'd2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4 + 2*CHK) @(negedge clk);
        chk("mid_op_valid_pre", op_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_op_valid", op_valid, 0);
        chk("mid_op", op, 0);
        chk("mid_rd_en", rd_en, 0);
        chk("mid_rd_row", rd_row, 0);
        chk("mid_rd_col", rd_col, 0);
        chk("mid_final", final_score, 0);
        chk("mid_err", err, 0);
        @(negedge clk); rst = 1'b0; op_ready = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (op_valid || rd_en || busy) act++;
        end
        chk("post_rst_quiet", act, 0);

`ifdef NW_TB_CHECK_EN
        // Corrupted H[1][1]: no consistent move from (2,2)
        s1 = 20'h4; s2 = 20'h4; fill(2, 2);
        hmem[1][1] = 16'd5;
        walk(2, 2, -1, 0);
        chk("chk_err", err, 1);
        chk("chk_ops", n_ops, 0);
        chk("chk_cycles", cycles, 6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
